seg7_seq_monitor: RTL and testbench

- Receive-side checker for a seven-segment counter output such as the BCD clock's seg_out.
- Samples a 7-bit segment pattern, filters glitches and decodes it back to a BCD digit.
- Verifies that successive digits follow the 0..9 wrap-around count and reports lock, sequence errors and invalid patterns.
- Instantiated in benches and on-chip self-test next to the counter it observes.

---
 rtl/seg7_pkg.sv | 47 ++++
 rtl/seg7_stable_filter.sv | 52 +++++
 rtl/seg7_seq_monitor.sv | 146 ++++++++++++++
 tb/tb_seg7_seq_monitor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment sequence monitor.
//   - SEG_* segment codes, ordered a..g with a as the leftmost bit of a [0:6] vector
//   - mon_state_e: sequence-tracking FSM state encoding
//   - seg7_to_bcd: maps a segment pattern to {illegal, digit[3:0]}
package seg7_pkg;

    localparam logic [0:6] SEG_0     = 7'b1111110;
    localparam logic [0:6] SEG_1     = 7'b0110000;
    localparam logic [0:6] SEG_2     = 7'b1101101;
    localparam logic [0:6] SEG_3     = 7'b1111001;
    localparam logic [0:6] SEG_4     = 7'b0110011;
    localparam logic [0:6] SEG_5     = 7'b1011011;
    localparam logic [0:6] SEG_6     = 7'b1011111;
    localparam logic [0:6] SEG_6_ALT = 7'b0011111;
    localparam logic [0:6] SEG_7     = 7'b1110000;
    localparam logic [0:6] SEG_7_ALT = 7'b1110010;
    localparam logic [0:6] SEG_8     = 7'b1111111;
    localparam logic [0:6] SEG_9     = 7'b1111011;
    localparam logic [0:6] SEG_9_ALT = 7'b1110011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } mon_state_e;

    // Returns {illegal, digit}; digit is 0 when illegal is set.
    function automatic logic [4:0] seg7_to_bcd(input logic [0:6] seg);
        logic [4:0] res;
        res = {1'b1, 4'd0};
        case (seg)
            SEG_0:                res = {1'b0, 4'd0};
            SEG_1:                res = {1'b0, 4'd1};
            SEG_2:                res = {1'b0, 4'd2};
            SEG_3:                res = {1'b0, 4'd3};
            SEG_4:                res = {1'b0, 4'd4};
            SEG_5:                res = {1'b0, 4'd5};
            SEG_6, SEG_6_ALT:     res = {1'b0, 4'd6};
            SEG_7, SEG_7_ALT:     res = {1'b0, 4'd7};
            SEG_8:                res = {1'b0, 4'd8};
            SEG_9, SEG_9_ALT:     res = {1'b0, 4'd9};
            default:              res = {1'b1, 4'd0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// seg7_stable_filter: glitch filter for a 7-bit segment pattern.
//   clk, rst     : clock, asynchronous active-high reset
//   enable_i     : sample enable; state freezes when low
//   seg_i [0:6]  : raw (polarity-corrected) pattern
//   seg_o [0:6]  : currently held pattern
//   accept_o     : combinational strobe, high on the edge the pattern becomes accepted,
//                  so the consumer can register its result on that same edge
module seg7_stable_filter #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic [0:6] seg_i,
    output logic [0:6] seg_o,
    output logic       accept_o
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [0:6] seg_q, seg_d;
    logic [7:0] cnt_q, cnt_d;

    // The counter saturates at STABLE, so reaching it happens once per stable run.
    always_comb begin
        seg_d    = seg_q;
        cnt_d    = cnt_q;
        accept_o = 1'b0;
        if (enable_i) begin
            if (seg_i != seg_q) begin
                seg_d = seg_i;
                cnt_d = 8'd1;
            end else if (cnt_q != STABLE) begin
                cnt_d    = cnt_q + 8'd1;
                accept_o = (cnt_q + 8'd1 == STABLE);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= '0;
            cnt_q <= '0;
        end else begin
            seg_q <= seg_d;
            cnt_q <= cnt_d;
        end
    end

    assign seg_o = seg_q;

endmodule

// File: rtl/seg7_seq_monitor.sv
// seg7_seq_monitor: checks that a seven-segment display counts 0..9 with wrap.
//   clk, rst         : clock, asynchronous active-high reset
//   enable           : sample enable; all state freezes when low
//   seg_in [0:6]     : segment pattern, index 0 = a .. index 6 = g
//   digit            : last accepted legal digit
//   digit_valid      : pulse on acceptance of a legal digit
//   locked           : LOCK_COUNT consecutive correct increments seen
//   seq_error        : pulse when an accepted digit is not the expected successor
//   invalid          : pulse when an accepted pattern is not a digit code
//   error_count      : saturating count of seq_error + invalid events
module seg7_seq_monitor
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned LOCK_COUNT    = 3,
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [0:6]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             locked,
    output logic             seq_error,
    output logic             invalid,
    output logic [ERR_W-1:0] error_count
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    logic [0:6] seg_pol, seg_acc;
    logic       accept;
    logic [4:0] dec;
    logic       illegal;
    logic [3:0] dec_digit, succ;

    mon_state_e       state_q, state_d;
    logic [3:0]       expected_q, expected_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       digit_q, digit_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             seqerr_q, seqerr_d;
    logic             inv_q, inv_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             bump;

    assign seg_pol = ACTIVE_LOW ? ~seg_in : seg_in;

    seg7_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .enable_i(enable),
        .seg_i   (seg_pol),
        .seg_o   (seg_acc),
        .accept_o(accept)
    );

    assign dec       = seg7_to_bcd(seg_acc);
    assign illegal   = dec[4];
    assign dec_digit = dec[3:0];
    assign succ      = (dec_digit == 4'd9) ? 4'd0 : dec_digit + 4'd1;

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        match_d    = match_q;
        digit_d    = digit_q;
        locked_d   = locked_q;
        valid_d    = 1'b0;
        seqerr_d   = 1'b0;
        inv_d      = 1'b0;
        bump       = 1'b0;
        if (accept) begin
            if (illegal) begin
                inv_d    = 1'b1;
                locked_d = 1'b0;
                state_d  = SEARCH;
                bump     = 1'b1;
            end else begin
                digit_d    = dec_digit;
                valid_d    = 1'b1;
                expected_d = succ;
                case (state_q)
                    TRACK, LOCKED: begin
                        if (dec_digit != expected_q) begin
                            // Resync on the offending digit.
                            seqerr_d = 1'b1;
                            locked_d = 1'b0;
                            match_d  = '0;
                            state_d  = TRACK;
                            bump     = 1'b1;
                        end else if (state_q == TRACK) begin
                            match_d = match_q + 4'd1;
                            if (match_q + 4'd1 == LOCK_CNT) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        match_d = '0;
                        state_d = TRACK;
                    end
                endcase
            end
        end
        err_d = (bump && err_q != '1) ? err_q + 1'b1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SEARCH;
            expected_q <= '0;
            match_q    <= '0;
            digit_q    <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            seqerr_q   <= 1'b0;
            inv_q      <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            match_q    <= match_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            seqerr_q   <= seqerr_d;
            inv_q      <= inv_d;
            err_q      <= err_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign locked      = locked_q;
    assign seq_error   = seqerr_q;
    assign invalid     = inv_q;
    assign error_count = err_q;

endmodule

// File: tb/tb_seg7_seq_monitor.sv
// tb_seg7_seq_monitor: bench for seg7_seq_monitor. Three instances share the stimulus:
// default parameters, ACTIVE_LOW=1 fed the inverted pattern, and ERR_W=2.
module tb_seg7_seq_monitor;

    localparam int S  = 4;
    localparam int NV = 27;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [0:6] seg = '0;
    logic [0:6] seg_n;

    assign seg_n = ~seg;

    logic [3:0] m_digit, a_digit, s_digit;
    logic       m_dv, a_dv, s_dv, m_lk, a_lk, s_lk;
    logic       m_se, a_se, s_se, m_inv, a_inv, s_inv;
    logic [7:0] m_err, a_err;
    logic [1:0] s_err;

    seg7_seq_monitor #(.STABLE_CYCLES(S), .LOCK_COUNT(3), .ACTIVE_LOW(1'b0), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .seg_in(seg),
        .digit(m_digit), .digit_valid(m_dv), .locked(m_lk),
        .seq_error(m_se), .invalid(m_inv), .error_count(m_err));

    seg7_seq_monitor #(.STABLE_CYCLES(S), .LOCK_COUNT(3), .ACTIVE_LOW(1'b1), .ERR_W(8)) dut_al (
        .clk(clk), .rst(rst), .enable(enable), .seg_in(seg_n),
        .digit(a_digit), .digit_valid(a_dv), .locked(a_lk),
        .seq_error(a_se), .invalid(a_inv), .error_count(a_err));

    seg7_seq_monitor #(.STABLE_CYCLES(S), .LOCK_COUNT(3), .ACTIVE_LOW(1'b0), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .seg_in(seg),
        .digit(s_digit), .digit_valid(s_dv), .locked(s_lk),
        .seq_error(s_se), .invalid(s_inv), .error_count(s_err));

    always #5 clk = ~clk;

    typedef struct {
        logic [0:6] pat;
        int         hold;
        bit         dv, se, inv;
        int         d;
        bit         lk;
        int         err;
    } vec_t;

    typedef struct {
        int due;
        bit dv, se, inv;
        int d;
        bit lk;
        int err;
    } ev_t;

    ev_t  q[$];
    vec_t tbl[NV];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic chk_inst(input string n, input logic dv, input logic se, input logic inv,
                            input logic [3:0] d, input logic lk, input int ec,
                            input bit due, input ev_t e, input int eerr);
        logic [2:0] gp, ep;
        gp = {dv, se, inv};
        ep = due ? {e.dv, e.se, e.inv} : 3'b000;
        chk({n, ".pulses(dv,se,inv)"}, int'(gp), int'(ep));
        if (due) begin
            chk({n, ".digit"}, int'(d), e.d);
            chk({n, ".locked"}, int'(lk), int'(e.lk));
            chk({n, ".error_count"}, ec, eerr);
        end
    endtask

    // Scoreboard: events are queued with the cycle they must appear on.
    always @(negedge clk) begin
        ev_t e;
        bit  due;
        e   = '{0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
        due = 1'b0;
        while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            chk("event_missed_due_cycle", cyc, e.due);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e   = q.pop_front();
            due = 1'b1;
        end
        chk_inst("main", m_dv, m_se, m_inv, m_digit, m_lk, int'(m_err), due, e, e.err);
        chk_inst("alow", a_dv, a_se, a_inv, a_digit, a_lk, int'(a_err), due, e, e.err);
        chk_inst("sat",  s_dv, s_se, s_inv, s_digit, s_lk, int'(s_err), due, e,
                 (e.err > 3) ? 3 : e.err);
    end

    // Called at a falling edge: drive the pattern, queue the expected result, hold.
    task automatic apply(input vec_t v);
        ev_t e;
        seg = v.pat;
        if (v.dv || v.inv) begin
            e = '{cyc + S, v.dv, v.se, v.inv, v.d, v.lk, v.err};
            q.push_back(e);
        end
        repeat (v.hold) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        pattern      hold dv    se    inv   d  lk    err
        tbl[0]  = '{7'b1111110, 8,  1'b1, 1'b0, 1'b0, 0, 1'b0, 0};
        tbl[1]  = '{7'b0110000, 8,  1'b1, 1'b0, 1'b0, 1, 1'b0, 0};
        tbl[2]  = '{7'b1101101, 8,  1'b1, 1'b0, 1'b0, 2, 1'b0, 0};
        tbl[3]  = '{7'b1111001, 8,  1'b1, 1'b0, 1'b0, 3, 1'b1, 0};
        tbl[4]  = '{7'b0110011, 12, 1'b1, 1'b0, 1'b0, 4, 1'b1, 0};
        tbl[5]  = '{7'b1011111, 8,  1'b1, 1'b1, 1'b0, 6, 1'b0, 1};
        tbl[6]  = '{7'b1001001, 8,  1'b0, 1'b0, 1'b1, 6, 1'b0, 2};
        tbl[7]  = '{7'b1011011, 8,  1'b1, 1'b0, 1'b0, 5, 1'b0, 2};
        tbl[8]  = '{7'b0011111, 8,  1'b1, 1'b0, 1'b0, 6, 1'b0, 2};
        tbl[9]  = '{7'b1110010, 8,  1'b1, 1'b0, 1'b0, 7, 1'b0, 2};
        tbl[10] = '{7'b1111111, 8,  1'b1, 1'b0, 1'b0, 8, 1'b1, 2};
        tbl[11] = '{7'b1111011, 8,  1'b1, 1'b0, 1'b0, 9, 1'b1, 2};
        tbl[12] = '{7'b1111110, 8,  1'b1, 1'b0, 1'b0, 0, 1'b1, 2};
        tbl[13] = '{7'b0110000, 8,  1'b1, 1'b0, 1'b0, 1, 1'b1, 2};
        tbl[14] = '{7'b1011011, 8,  1'b1, 1'b1, 1'b0, 5, 1'b0, 3};
        tbl[15] = '{7'b1111111, 2,  1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
        tbl[16] = '{7'b1011011, 8,  1'b1, 1'b1, 1'b0, 5, 1'b0, 4};
        tbl[17] = '{7'b1110011, 8,  1'b1, 1'b1, 1'b0, 9, 1'b0, 5};
        tbl[18] = '{7'b1111110, 8,  1'b1, 1'b0, 1'b0, 0, 1'b0, 5};
        tbl[19] = '{7'b0110000, 8,  1'b1, 1'b0, 1'b0, 1, 1'b0, 5};
        tbl[20] = '{7'b1101101, 8,  1'b1, 1'b0, 1'b0, 2, 1'b1, 5};
        tbl[21] = '{7'b1110000, 8,  1'b1, 1'b1, 1'b0, 7, 1'b0, 6};
        tbl[22] = '{7'b0000000, 8,  1'b0, 1'b0, 1'b1, 7, 1'b0, 7};
        tbl[23] = '{7'b1001001, 8,  1'b0, 1'b0, 1'b1, 7, 1'b0, 8};
        tbl[24] = '{7'b0000001, 8,  1'b0, 1'b0, 1'b1, 7, 1'b0, 9};
        tbl[25] = '{7'b1000000, 8,  1'b0, 1'b0, 1'b1, 7, 1'b0, 10};
        tbl[26] = '{7'b0000001, 8,  1'b0, 1'b0, 1'b1, 7, 1'b0, 11};

        rst    = 1'b1;
        enable = 1'b1;
        seg    = '0;
        repeat (2) @(negedge clk);
        chk("reset.digit", int'(m_digit), 0);
        chk("reset.digit_valid", int'(m_dv), 0);
        chk("reset.locked", int'(m_lk), 0);
        chk("reset.seq_error", int'(m_se), 0);
        chk("reset.invalid", int'(m_inv), 0);
        chk("reset.error_count", int'(m_err), 0);

        rst = 1'b0;
        for (int i = 0; i < NV; i++) apply(tbl[i]);

        // Enable freeze: pattern changes while disabled are ignored until re-enabled.
        apply('{7'b1111001, 8, 1'b1, 1'b0, 1'b0, 3, 1'b0, 11});
        enable = 1'b0;
        seg    = 7'b0110011;
        repeat (3) @(negedge clk);
        seg    = 7'b1011011;
        repeat (6) @(negedge clk);
        chk("frozen.digit", int'(m_digit), 3);
        chk("frozen.locked", int'(m_lk), 0);
        chk("frozen.error_count", int'(m_err), 11);
        enable = 1'b1;
        apply('{7'b0110011, 8, 1'b1, 1'b0, 1'b0, 4, 1'b0, 11});

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        chk("async_rst.digit", int'(m_digit), 0);
        chk("async_rst.error_count", int'(m_err), 0);
        chk("async_rst.locked", int'(m_lk), 0);
        chk("async_rst.alow_digit", int'(a_digit), 0);
        chk("async_rst.sat_error_count", int'(s_err), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply('{7'b0110000, 8, 1'b1, 1'b0, 1'b0, 1, 1'b0, 0});

        repeat (S + 2) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
